// File: rtl/rob_commit_unit.sv
// In-order reorder buffer: allocates entries at issue, records writebacks and retires one
// entry per cycle from the head. Define ROB_WB_BYPASS_EN to forward writebacks to operand lookup.
module rob_commit_unit #(
    parameter int unsigned ROB_WIDTH_BIT = 3
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,

    input  logic                     issue_valid,
    input  logic [4:0]               issue_rd,
    input  logic                     issue_is_br,
    output logic                     issue_ready,
    output logic [4:0]               new_reg_id,
    output logic [ROB_WIDTH_BIT-1:0] new_ROB_id,

    input  logic                     wb_valid,
    input  logic [ROB_WIDTH_BIT-1:0] wb_rob_id,
    input  logic [31:0]              wb_val,
    input  logic                     wb_mispred,
    input  logic [31:0]              wb_target,

    output logic [4:0]               write_reg_id,
    output logic [ROB_WIDTH_BIT-1:0] write_ROB_id,
    output logic [31:0]              write_val,

    input  logic [ROB_WIDTH_BIT-1:0] rs1_id,
    input  logic [ROB_WIDTH_BIT-1:0] rs2_id,
    output logic                     rs1_ready,
    output logic                     rs2_ready,
    output logic [31:0]              rs1_val,
    output logic [31:0]              rs2_val,

    output logic                     clear_flag,
    output logic [31:0]              clear_pc
);

    localparam int unsigned DEPTH = 1 << ROB_WIDTH_BIT;
    localparam logic [ROB_WIDTH_BIT:0] DEPTH_CNT = (ROB_WIDTH_BIT + 1)'(DEPTH);

    logic [ROB_WIDTH_BIT-1:0] head_q, tail_q;
    logic [ROB_WIDTH_BIT:0]   count_q;

    logic [DEPTH-1:0] busy_q, ready_q, is_br_q, mispred_q;
    logic [4:0]       rd_q     [DEPTH];
    logic [31:0]      val_q    [DEPTH];
    logic [31:0]      target_q [DEPTH];

    logic issue_fire, commit_fire, wb_fire, flush;

    // issue_ready looks only at the registered count, so a full buffer never
    // accepts an issue even when it commits in the same cycle.
    assign issue_ready = (count_q < DEPTH_CNT) && !clear_flag && rdy_in;
    assign issue_fire  = issue_valid && issue_ready;
    assign commit_fire = busy_q[head_q] && ready_q[head_q] && rdy_in && !clear_flag;
    assign wb_fire     = wb_valid && busy_q[wb_rob_id] && rdy_in && !clear_flag;
    assign flush       = commit_fire && mispred_q[head_q];

    assign new_reg_id   = issue_fire ? issue_rd : 5'd0;
    assign new_ROB_id   = tail_q;
    assign write_reg_id = commit_fire ? rd_q[head_q] : 5'd0;
    assign write_ROB_id = commit_fire ? head_q : '0;
    assign write_val    = commit_fire ? val_q[head_q] : 32'd0;

    // Branch flag is kept with the entry for debug visibility only.
    logic unused_is_br;
    assign unused_is_br = ^is_br_q;

    always_comb begin
        rs1_ready = ready_q[rs1_id];
        rs1_val   = val_q[rs1_id];
        rs2_ready = ready_q[rs2_id];
        rs2_val   = val_q[rs2_id];
`ifdef ROB_WB_BYPASS_EN
        if (wb_valid && (wb_rob_id == rs1_id) && busy_q[rs1_id]) begin
            rs1_ready = 1'b1;
            rs1_val   = wb_val;
        end
        if (wb_valid && (wb_rob_id == rs2_id) && busy_q[rs2_id]) begin
            rs2_ready = 1'b1;
            rs2_val   = wb_val;
        end
`endif
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            busy_q     <= '0;
            ready_q    <= '0;
            is_br_q    <= '0;
            mispred_q  <= '0;
            clear_flag <= 1'b0;
            clear_pc   <= 32'd0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                rd_q[i]     <= 5'd0;
                val_q[i]    <= 32'd0;
                target_q[i] <= 32'd0;
            end
        end else if (rdy_in) begin
            clear_flag <= flush;
            if (flush) begin
                clear_pc <= target_q[head_q];
                busy_q   <= '0;
                ready_q  <= '0;
                head_q   <= '0;
                tail_q   <= '0;
                count_q  <= '0;
            end else begin
                if (wb_fire) begin
                    ready_q[wb_rob_id]   <= 1'b1;
                    val_q[wb_rob_id]     <= wb_val;
                    mispred_q[wb_rob_id] <= wb_mispred;
                    target_q[wb_rob_id]  <= wb_target;
                end
                // Placed after the writeback so freeing the head wins on a shared index.
                if (commit_fire) begin
                    busy_q[head_q]  <= 1'b0;
                    ready_q[head_q] <= 1'b0;
                    head_q          <= head_q + ROB_WIDTH_BIT'(1);
                end
                if (issue_fire) begin
                    busy_q[tail_q]    <= 1'b1;
                    ready_q[tail_q]   <= 1'b0;
                    mispred_q[tail_q] <= 1'b0;
                    rd_q[tail_q]      <= issue_rd;
                    is_br_q[tail_q]   <= issue_is_br;
                    tail_q            <= tail_q + ROB_WIDTH_BIT'(1);
                end
                count_q <= count_q + (ROB_WIDTH_BIT + 1)'(issue_fire)
                                   - (ROB_WIDTH_BIT + 1)'(commit_fire);
            end
        end
    end

endmodule
